// File: rtl/cnf_word_loader_pkg.sv
// Shared definitions for the CNF word loader.
// Contents: clause word width, default buffer depth, and the loader FSM state type.
package cnf_word_loader_pkg;

    // Width of one clause word as consumed by the solver.
    localparam int unsigned number_literal = 30;

    // Default depth of the problem buffer, in words.
    localparam int unsigned LOADER_MAX_WORDS = 128;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        REPLAY,
        WAIT_END
    } loader_state_t;

endpackage

// File: rtl/cnf_word_loader_if.sv
// Byte-wide host stream carrying clause words into the loader.
// Signals: s_data (byte), s_valid (byte valid), s_last (final byte of the problem),
//          s_ready (loader accepts this cycle).
// Modports: master = host side, slave = loader side.
interface cnf_word_loader_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/word_buffer_ram.sv
// Simple dual-port word buffer: one write port, one synchronous read port
// (one-cycle latency). No reset so it maps onto block RAM.
// Ports: clock; we/waddr/wdata write port; raddr read address; rdata registered read data.
module word_buffer_ram #(
    parameter int unsigned WIDTH = 30,
    parameter int unsigned DEPTH = 128
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/cnf_word_loader.sv
// Upstream feeder for the SAT solver. Assembles MSB-first host bytes into LIT_W-bit
// clause words, buffers a whole problem, replays it as a gap-free burst on load/i,
// then waits for the solver's ended before taking the next problem.
// Ports: clock, reset (sync, active-high); host (byte stream, slave side);
//        ended (solver done); load/i (burst to solver); busy (not IDLE);
//        err (sticky framing/overflow error, cleared by the next problem's first byte).
module cnf_word_loader
    import cnf_word_loader_pkg::*;
#(
    parameter int unsigned LIT_W     = number_literal,
    parameter int unsigned MAX_WORDS = LOADER_MAX_WORDS
) (
    input  logic               clock,
    input  logic               reset,
    cnf_word_loader_if.slave   host,
    input  logic               ended,
    output logic               load,
    output logic [LIT_W-1:0]   i,
    output logic               busy,
    output logic               err
);

    localparam int unsigned BYTES = (LIT_W + 7) / 8;
    localparam int unsigned SW    = BYTES * 8;
    localparam int unsigned AW    = $clog2(MAX_WORDS);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    loader_state_t   state_q, state_d;
    logic [SW-1:0]   shreg_q, shreg_d, sh_next;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [CW-1:0]   rcnt_q, rcnt_d;
    logic            drop_q, drop_d;
    logic            err_q, err_d;
    logic            load_q, load_d;

    logic            accept;
    logic            we;
    logic [AW-1:0]   waddr, raddr;
    logic [LIT_W-1:0] wdata, rdata;

    // Read-during-write bypass: a one-word problem reads address 0 on the same edge
    // that writes it.
    logic             fwd_q;
    logic [LIT_W-1:0] fwd_data_q;

    assign host.s_ready = (state_q == IDLE) || (state_q == COLLECT);
    assign accept       = host.s_valid && host.s_ready;
    assign sh_next      = (shreg_q << 8) | SW'(host.s_data);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        drop_d  = drop_q;
        err_d   = err_q;
        load_d  = 1'b0;
        we      = 1'b0;
        waddr   = wcnt_q[AW-1:0];
        wdata   = sh_next[LIT_W-1:0];
        raddr   = rcnt_q[AW-1:0];

        unique case (state_q)
            IDLE, COLLECT: begin
                if (accept) begin
                    if (state_q == IDLE) begin
                        err_d = 1'b0;
                    end
                    state_d = COLLECT;
                    if (drop_q) begin
                        // Draining an overflowed stream up to its last byte.
                        if (host.s_last) begin
                            state_d = IDLE;
                            drop_d  = 1'b0;
                            wcnt_d  = '0;
                            bcnt_d  = '0;
                            shreg_d = '0;
                        end
                    end else if (bcnt_q == '0 && wcnt_q == CW'(MAX_WORDS)) begin
                        err_d = 1'b1;
                        if (host.s_last) begin
                            state_d = IDLE;
                            wcnt_d  = '0;
                            bcnt_d  = '0;
                            shreg_d = '0;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end else if (bcnt_q == BW'(BYTES - 1)) begin
                        we      = 1'b1;
                        wcnt_d  = wcnt_q + CW'(1);
                        bcnt_d  = '0;
                        shreg_d = sh_next;
                        if (host.s_last) begin
                            // Issue read of word 0 now so it is on i the next cycle.
                            state_d = REPLAY;
                            raddr   = '0;
                            rcnt_d  = CW'(1);
                            load_d  = 1'b1;
                        end
                    end else begin
                        shreg_d = sh_next;
                        bcnt_d  = bcnt_q + BW'(1);
                        if (host.s_last) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                            wcnt_d  = '0;
                            bcnt_d  = '0;
                            shreg_d = '0;
                        end
                    end
                end
            end
            REPLAY: begin
                if (rcnt_q < wcnt_q) begin
                    load_d = 1'b1;
                    rcnt_d = rcnt_q + CW'(1);
                end else begin
                    state_d = WAIT_END;
                    rcnt_d  = '0;
                end
            end
            WAIT_END: begin
                if (ended) begin
                    wcnt_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

    always_ff @(posedge clock) begin
        fwd_q      <= we && (waddr == raddr);
        fwd_data_q <= wdata;
    end

    word_buffer_ram #(
        .WIDTH (LIT_W),
        .DEPTH (MAX_WORDS)
    ) u_ram (
        .clock (clock),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign load = load_q;
    assign i    = load_q ? (fwd_q ? fwd_data_q : rdata) : '0;
    assign busy = (state_q != IDLE);
    assign err  = err_q;

endmodule
